// File: rtl/rtcl_p3s7_hs_pkg.sv
//------------------------------------------------------------------------------
// Module   : rtcl_p3s7_hs_pkg
// Brief    : Shared types for the frame splitter: FSM state, pixel and beat.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rtcl_p3s7_hs_pkg;

    localparam int RAW_BITS_DEF = 10;
    localparam int CHANNELS_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLACK = 2'd1,
        ST_IMAGE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [RAW_BITS_DEF-1:0] raw_t;

    typedef struct packed {
        raw_t [CHANNELS_DEF-1:0] pix;
        logic                    user;
        logic                    last;
    } beat_t;

endpackage

`default_nettype wire

// File: rtl/rtcl_p3s7_hs_axi4s_out_reg.sv
//------------------------------------------------------------------------------
// Module   : rtcl_p3s7_hs_axi4s_out_reg
// Brief    : Single-entry AXI4-Stream output register; a beat arriving while the
//            held beat is stalled is dropped and reported on drop_o.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rtcl_p3s7_hs_axi4s_out_reg
    import rtcl_p3s7_hs_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              user_i,
    input  logic              last_i,
    output logic              busy_o,
    output logic              drop_o,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tuser_o,
    output logic              tlast_o,
    output logic              tvalid_o,
    input  logic              tready_i
);

    logic [DATA_W-1:0] tdata_q;
    logic              tuser_q;
    logic              tlast_q;
    logic              tvalid_q;

    assign busy_o = tvalid_q && !tready_i;
    assign drop_o = aclken && load_i && busy_o;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (aclken) begin
            if (load_i && !busy_o) begin
                tdata_q  <= data_i;
                tuser_q  <= user_i;
                tlast_q  <= last_i;
                tvalid_q <= 1'b1;
            end else if (tready_i) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign tdata_o  = tdata_q;
    assign tuser_o  = tuser_q;
    assign tlast_o  = tlast_q;
    assign tvalid_o = tvalid_q;

endmodule

`default_nettype wire

// File: rtl/rtcl_p3s7_hs_frame_split.sv
//------------------------------------------------------------------------------
// Module   : rtcl_p3s7_hs_frame_split
// Brief    : Splits a row-packet pixel stream into black-row and image-row
//            AXI4-Streams, enforcing row widths. Error counters are built only
//            when RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rtcl_p3s7_hs_frame_split
    import rtcl_p3s7_hs_pkg::*;
#(
    parameter int X_BITS   = 10,
    parameter int Y_BITS   = 10,
    parameter int CHANNELS = 1,
    parameter int RAW_BITS = 10,
    parameter int CNT_BITS = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         aclken,
    input  logic [X_BITS-1:0]            param_black_width,
    input  logic [Y_BITS-1:0]            param_black_height,
    input  logic [X_BITS-1:0]            param_image_width,
    input  logic [Y_BITS-1:0]            param_image_height,
    input  logic                         frame_start,
    input  logic                         s_first,
    input  logic                         s_last,
    input  logic [CHANNELS*RAW_BITS-1:0] s_data,
    input  logic                         s_valid,
    output logic [CHANNELS*RAW_BITS-1:0] m_black_tdata,
    output logic                         m_black_tuser,
    output logic                         m_black_tlast,
    output logic                         m_black_tvalid,
    input  logic                         m_black_tready,
    output logic [CHANNELS*RAW_BITS-1:0] m_image_tdata,
    output logic                         m_image_tuser,
    output logic                         m_image_tlast,
    output logic                         m_image_tvalid,
    input  logic                         m_image_tready,
    input  logic                         err_clear,
    output logic                         err_overflow,
    output logic                         err_short,
    output logic [CNT_BITS-1:0]          cnt_short,
    output logic [CNT_BITS-1:0]          cnt_long,
    output logic [CNT_BITS-1:0]          cnt_drop
);

    localparam int DATA_W = CHANNELS * RAW_BITS;

    state_t            state_q, state_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [X_BITS-1:0] width_q, width_d;
    logic              in_row_q, in_row_d;
    logic              fs_black_q, fs_black_d;
    logic              fs_image_q, fs_image_d;
    logic              err_overflow_q, err_short_q;

    logic emit_black, emit_image, beat_user, beat_last, inc_short;
    logic black_busy, image_busy, black_drop, image_drop;
`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
    logic long_q, long_d, inc_long;
`endif

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        x_d        = x_q;
        width_d    = width_q;
        in_row_d   = in_row_q;
        fs_black_d = fs_black_q;
        fs_image_d = fs_image_q;
        emit_black = 1'b0;
        emit_image = 1'b0;
        beat_user  = 1'b0;
        beat_last  = 1'b0;
        inc_short  = 1'b0;
`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
        long_d     = long_q;
        inc_long   = 1'b0;
`endif

        // Frame start is resolved first so a coincident beat lands in the new frame.
        if (frame_start) begin
            y_d      = '0;
            in_row_d = 1'b0;
            if (param_black_height != '0) begin
                state_d = ST_BLACK;
            end else if (param_image_height != '0) begin
                state_d = ST_IMAGE;
            end else begin
                state_d = ST_DONE;
            end
            fs_black_d = (state_d == ST_BLACK);
            fs_image_d = (state_d == ST_IMAGE);
        end

        if (s_valid && (state_d == ST_BLACK || state_d == ST_IMAGE)) begin
            if (s_first) begin
                if (in_row_d) begin
                    inc_short = 1'b1;
                end
                in_row_d = 1'b1;
                x_d      = '0;
                width_d  = (state_d == ST_BLACK) ? param_black_width : param_image_width;
`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
                long_d   = 1'b0;
`endif
            end

            if (in_row_d) begin
                if (x_d < width_d) begin
                    beat_last = (x_d == width_d - X_BITS'(1)) || s_last;
                    if (s_last && (x_d != width_d - X_BITS'(1))) begin
                        inc_short = 1'b1;
                    end
                    if (state_d == ST_BLACK) begin
                        emit_black = 1'b1;
                        beat_user  = fs_black_d;
                        if (!black_busy) begin
                            fs_black_d = 1'b0;
                        end
                    end else begin
                        emit_image = 1'b1;
                        beat_user  = fs_image_d;
                        if (!image_busy) begin
                            fs_image_d = 1'b0;
                        end
                    end
                end else begin
`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
                    if (!long_d) begin
                        inc_long = 1'b1;
                        long_d   = 1'b1;
                    end
`endif
                end

                if (x_d != '1) begin
                    x_d = x_d + X_BITS'(1);
                end

                if (s_last) begin
                    in_row_d = 1'b0;
                    if (state_d == ST_BLACK && y_d == param_black_height - Y_BITS'(1)) begin
                        y_d = '0;
                        if (param_image_height != '0) begin
                            state_d    = ST_IMAGE;
                            fs_image_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (state_d == ST_IMAGE && y_d == param_image_height - Y_BITS'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        y_d = y_d + Y_BITS'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            y_q            <= '0;
            x_q            <= '0;
            width_q        <= '0;
            in_row_q       <= 1'b0;
            fs_black_q     <= 1'b0;
            fs_image_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            err_short_q    <= 1'b0;
        end else if (aclken) begin
            state_q        <= state_d;
            y_q            <= y_d;
            x_q            <= x_d;
            width_q        <= width_d;
            in_row_q       <= in_row_d;
            fs_black_q     <= fs_black_d;
            fs_image_q     <= fs_image_d;
            err_overflow_q <= err_clear ? 1'b0 : (err_overflow_q || black_drop || image_drop);
            err_short_q    <= err_clear ? 1'b0 : (err_short_q || inc_short);
        end
    end

    assign err_overflow = err_overflow_q;
    assign err_short    = err_short_q;

`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
    logic [CNT_BITS-1:0] cnt_short_q, cnt_long_q, cnt_drop_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            long_q      <= 1'b0;
            cnt_short_q <= '0;
            cnt_long_q  <= '0;
            cnt_drop_q  <= '0;
        end else if (aclken) begin
            long_q <= long_d;
            if (err_clear) begin
                cnt_short_q <= '0;
                cnt_long_q  <= '0;
                cnt_drop_q  <= '0;
            end else begin
                if (inc_short && cnt_short_q != '1) cnt_short_q <= cnt_short_q + CNT_BITS'(1);
                if (inc_long && cnt_long_q != '1)   cnt_long_q  <= cnt_long_q + CNT_BITS'(1);
                if ((black_drop || image_drop) && cnt_drop_q != '1)
                    cnt_drop_q <= cnt_drop_q + CNT_BITS'(1);
            end
        end
    end

    assign cnt_short = cnt_short_q;
    assign cnt_long  = cnt_long_q;
    assign cnt_drop  = cnt_drop_q;
`else
    assign cnt_short = '0;
    assign cnt_long  = '0;
    assign cnt_drop  = '0;
`endif

    rtcl_p3s7_hs_axi4s_out_reg #(.DATA_W(DATA_W)) u_black_out (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .aclken   (aclken),
        .load_i   (emit_black),
        .data_i   (s_data),
        .user_i   (beat_user),
        .last_i   (beat_last),
        .busy_o   (black_busy),
        .drop_o   (black_drop),
        .tdata_o  (m_black_tdata),
        .tuser_o  (m_black_tuser),
        .tlast_o  (m_black_tlast),
        .tvalid_o (m_black_tvalid),
        .tready_i (m_black_tready)
    );

    rtcl_p3s7_hs_axi4s_out_reg #(.DATA_W(DATA_W)) u_image_out (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .aclken   (aclken),
        .load_i   (emit_image),
        .data_i   (s_data),
        .user_i   (beat_user),
        .last_i   (beat_last),
        .busy_o   (image_busy),
        .drop_o   (image_drop),
        .tdata_o  (m_image_tdata),
        .tuser_o  (m_image_tuser),
        .tlast_o  (m_image_tlast),
        .tvalid_o (m_image_tvalid),
        .tready_i (m_image_tready)
    );

endmodule

`default_nettype wire

// File: tb/tb_rtcl_p3s7_hs_frame_split.sv
//------------------------------------------------------------------------------
// Module   : tb_rtcl_p3s7_hs_frame_split
// Brief    : Scoreboard bench for the black/image frame splitter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rtcl_p3s7_hs_frame_split;

`ifdef RTCL_P3S7_HS_FRAME_SPLIT_ERRCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn, aclken;
    logic [9:0]  param_black_width, param_image_width;
    logic [9:0]  param_black_height, param_image_height;
    logic        frame_start, s_first, s_last, s_valid;
    logic [9:0]  s_data;
    logic [9:0]  m_black_tdata, m_image_tdata;
    logic        m_black_tuser, m_black_tlast, m_black_tvalid, m_black_tready;
    logic        m_image_tuser, m_image_tlast, m_image_tvalid, m_image_tready;
    logic        err_clear, err_overflow, err_short;
    logic [15:0] cnt_short, cnt_long, cnt_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int black_seen = 0;
    int bs;
    logic [11:0] qb[$];
    logic [11:0] qi[$];

    always #5 aclk = ~aclk;

    rtcl_p3s7_hs_frame_split dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .aclken             (aclken),
        .param_black_width  (param_black_width),
        .param_black_height (param_black_height),
        .param_image_width  (param_image_width),
        .param_image_height (param_image_height),
        .frame_start        (frame_start),
        .s_first            (s_first),
        .s_last             (s_last),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .m_black_tdata      (m_black_tdata),
        .m_black_tuser      (m_black_tuser),
        .m_black_tlast      (m_black_tlast),
        .m_black_tvalid     (m_black_tvalid),
        .m_black_tready     (m_black_tready),
        .m_image_tdata      (m_image_tdata),
        .m_image_tuser      (m_image_tuser),
        .m_image_tlast      (m_image_tlast),
        .m_image_tvalid     (m_image_tvalid),
        .m_image_tready     (m_image_tready),
        .err_clear          (err_clear),
        .err_overflow       (err_overflow),
        .err_short          (err_short),
        .cnt_short          (cnt_short),
        .cnt_long           (cnt_long),
        .cnt_drop           (cnt_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected beats are packed as {data, tuser, tlast}.
    task automatic exp_beat(input bit img, input logic [9:0] d, input bit u, input bit l);
        if (img) qi.push_back({d, u, l});
        else     qb.push_back({d, u, l});
    endtask

    task automatic exp_row(input bit img, input logic [9:0] base, input int n_emit,
                           input bit first_user, input int last_at);
        for (int i = 0; i < n_emit; i++)
            exp_beat(img, base + 10'(i), first_user && (i == 0), i == last_at);
    endtask

    task automatic send_row(input int n, input logic [9:0] base, input int stall_at, input int stall_len);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            s_valid = 1'b1;
            s_first = (i == 0);
            s_last  = (i == n - 1);
            s_data  = base + 10'(i);
            if (i == stall_at)             m_image_tready = 1'b0;
            if (i == stall_at + stall_len) m_image_tready = 1'b1;
        end
        @(posedge aclk); #1;
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    endtask

    task automatic pulse_fs();
        @(posedge aclk); #1; frame_start = 1'b1;
        @(posedge aclk); #1; frame_start = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge aclk);
        #1;
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_black_tvalid) black_seen++;
            if (m_black_tvalid && m_black_tready) begin
                if (qb.size() == 0) chk("black_unexpected_beat", {m_black_tdata, m_black_tuser, m_black_tlast}, 32'hFFFF_FFFF);
                else chk("black_beat", {m_black_tdata, m_black_tuser, m_black_tlast}, qb.pop_front());
            end
            if (m_image_tvalid && m_image_tready) begin
                if (qi.size() == 0) chk("image_unexpected_beat", {m_image_tdata, m_image_tuser, m_image_tlast}, 32'hFFFF_FFFF);
                else chk("image_beat", {m_image_tdata, m_image_tuser, m_image_tlast}, qi.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; aclken = 1'b1;
        frame_start = 1'b0; s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0; s_data = '0;
        m_black_tready = 1'b1; m_image_tready = 1'b1; err_clear = 1'b0;
        param_black_width = 10'd4; param_black_height = 10'd2;
        param_image_width = 10'd8; param_image_height = 10'd3;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_black_tvalid", m_black_tvalid, 0);
        chk("rst_image_tvalid", m_image_tvalid, 0);
        chk("rst_tuser_tlast", {m_black_tuser, m_black_tlast, m_image_tuser, m_image_tlast}, 0);
        chk("rst_tdata", {m_black_tdata, m_image_tdata}, 0);
        chk("rst_flags", {err_overflow, err_short}, 0);
        chk("rst_counters", {cnt_short, cnt_long} | cnt_drop, 0);
        aresetn = 1'b1;

        // Nominal frame, then a row after the frame is complete (dropped).
        pulse_fs();
        exp_row(0, 10'h100, 4, 1, 3); send_row(4, 10'h100, -1, 0);
        exp_row(0, 10'h110, 4, 0, 3); send_row(4, 10'h110, -1, 0);
        for (int r = 0; r < 3; r++) begin
            exp_row(1, 10'h120 + 10'(16 * r), 8, r == 0, 7);
            send_row(8, 10'h120 + 10'(16 * r), -1, 0);
        end
        send_row(4, 10'h180, -1, 0);
        drain();
        chk("t1_black_q_empty", qb.size(), 0);
        chk("t1_image_q_empty", qi.size(), 0);
        chk("t1_no_errors", {err_overflow, err_short}, 0);

        // Long row, short row, stalled row.
        pulse_fs();
        exp_row(0, 10'h1A0, 4, 1, 3); send_row(4, 10'h1A0, -1, 0);
        exp_row(0, 10'h1B0, 4, 0, 3); send_row(4, 10'h1B0, -1, 0);
        exp_row(1, 10'h200, 8, 1, 7); send_row(10, 10'h200, -1, 0);
        drain();
        chk("long_cnt_long", cnt_long, CNT_EN);
        chk("long_no_short", err_short, 0);
        exp_row(1, 10'h220, 5, 0, 4); send_row(5, 10'h220, -1, 0);
        drain();
        chk("short_err_short", err_short, 1);
        chk("short_cnt_short", cnt_short, CNT_EN);
        exp_beat(1, 10'h240, 0, 0);
        for (int i = 4; i < 8; i++) exp_beat(1, 10'h240 + 10'(i), 0, i == 7);
        send_row(8, 10'h240, 1, 3);
        drain();
        chk("stall_err_overflow", err_overflow, 1);
        chk("stall_cnt_drop", cnt_drop, 3 * CNT_EN);
        chk("t2_image_q_empty", qi.size(), 0);
        chk("t2_black_q_empty", qb.size(), 0);
        @(posedge aclk); #1; err_clear = 1'b1;
        @(posedge aclk); #1; err_clear = 1'b0;
        chk("clear_flags", {err_overflow, err_short}, 0);
        chk("clear_counters", {cnt_short, cnt_long, cnt_drop}, 0);

        // No black rows: everything goes to image.
        param_black_height = 10'd0; param_image_width = 10'd4; param_image_height = 10'd2;
        bs = black_seen;
        pulse_fs();
        exp_row(1, 10'h300, 4, 1, 3); send_row(4, 10'h300, -1, 0);
        exp_row(1, 10'h310, 4, 0, 3); send_row(4, 10'h310, -1, 0);
        drain();
        chk("noblack_black_idle", black_seen - bs, 0);
        chk("noblack_image_q_empty", qi.size(), 0);

        // Frame restart mid-frame, then asynchronous reset mid-row.
        param_black_height = 10'd2; param_image_width = 10'd8; param_image_height = 10'd3;
        pulse_fs();
        exp_row(0, 10'h400, 4, 1, 3); send_row(4, 10'h400, -1, 0);
        exp_row(0, 10'h410, 4, 0, 3); send_row(4, 10'h410, -1, 0);
        exp_row(1, 10'h420, 8, 1, 7); send_row(8, 10'h420, -1, 0);
        exp_row(1, 10'h430, 8, 0, 7); send_row(8, 10'h430, -1, 0);
        pulse_fs();
        exp_row(0, 10'h440, 4, 1, 3); send_row(4, 10'h440, -1, 0);
        exp_beat(0, 10'h450, 0, 0);
        @(posedge aclk); #1;
        s_valid = 1'b1; s_first = 1'b1; s_last = 1'b0; s_data = 10'h450;
        @(posedge aclk); #1;
        s_first = 1'b0; s_data = 10'h451;
        @(posedge aclk); #1;
        chk("pre_reset_black_tvalid", m_black_tvalid, 1);
        #1; aresetn = 1'b0;
        #1;
        chk("async_rst_black_tvalid", m_black_tvalid, 0);
        chk("async_rst_black_tdata", m_black_tdata, 0);
        chk("async_rst_image_tvalid", m_image_tvalid, 0);
        s_valid = 1'b0; s_first = 1'b0;
        repeat (2) @(posedge aclk);
        #1; aresetn = 1'b1;
        drain();
        chk("t4_black_q_empty", qb.size(), 0);
        chk("t4_image_q_empty", qi.size(), 0);
        chk("t4_black_tvalid_idle", m_black_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
